rgb_pwm_driver: RTL and testbench

Downstream consumer of the HSV-to-RGB converter: takes its 8-bit R, G, B channel values and drives three PWM pins of an RGB LED. New channel values are latched only at PWM period boundaries, so the LED never sees a truncated or glitched period. An optional soft-fade mode ramps each duty cycle toward its target by one step per period.

---
 rtl/rgb_pwm_driver.sv | 171 +++++++++++++++++
 tb/tb_rgb_pwm_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
//
// Drives the three PWM pins of an RGB LED from the 8-bit R/G/B channel
// values produced by the HSV-to-RGB converter. Each channel's duty is
// latched only when the 255-tick PWM period wraps, so the LED never sees a
// truncated or glitched period.
//
// Parameters:
//   PRESC         clocks per PWM tick (1..65535)
//   COMMON_ANODE  1 = invert all LED outputs (active-low LED)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   R, G, B       8-bit target duties, sampled every cycle
//   enable        1 = PWM running, 0 = LEDs held at the inactive level
//   led_r/g/b     registered PWM pins
//   period_start  one-cycle pulse after every PWM counter wrap
//   settled       1 when all applied duties equal the current R/G/B
//
// Build option:
//   RGB_PWM_SOFT_FADE_EN  when defined, each duty moves one step toward its
//                         target per period instead of jumping to it.

module rgb_pwm_driver #(
  parameter int unsigned PRESC        = 4,
  parameter int unsigned COMMON_ANODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic       enable,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       period_start,
  output logic       settled
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESC - 1);
  localparam logic [7:0]  CNT_MAX   = 8'd254;
  localparam logic        INACTIVE  = (COMMON_ANODE != 0);

  // Prescaler and PWM counter
  logic [15:0] pcnt_q, pcnt_d;
  logic [7:0]  cnt_q, cnt_d;

  // Applied duties
  logic [7:0]  dr_q, dr_d;
  logic [7:0]  dg_q, dg_d;
  logic [7:0]  db_q, db_d;

  // Registered outputs
  logic        led_r_q, led_r_d;
  logic        led_g_q, led_g_d;
  logic        led_b_q, led_b_d;
  logic        period_start_q, period_start_d;
  logic        settled_q, settled_d;

  logic        tick;
  logic        wrap;

`ifdef RGB_PWM_SOFT_FADE_EN
  // One step toward the target; equal values stay put.
  function automatic logic [7:0] fade_step(input logic [7:0] cur,
                                           input logic [7:0] tgt);
    logic [7:0] nxt;
    nxt = cur;
    if (tgt > cur) begin
      nxt = cur + 8'd1;
    end else if (tgt < cur) begin
      nxt = cur - 8'd1;
    end
    return nxt;
  endfunction
`endif

  // Tick and wrap only exist while running, so a falling enable in the
  // wrap cycle suppresses the pulse and the duty update by the fade path.
  assign tick = enable && (pcnt_q == PRESC_MAX);
  assign wrap = tick && (cnt_q == CNT_MAX);

  // Prescaler and PWM counter
  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!enable) begin
      pcnt_d = 16'd0;
      cnt_d  = 8'd0;
    end else if (tick) begin
      pcnt_d = 16'd0;
      cnt_d  = wrap ? 8'd0 : cnt_q + 8'd1;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  // Duty registers: follow the inputs directly while disabled, otherwise
  // change only on the wrap edge.
  always_comb begin
    dr_d = dr_q;
    dg_d = dg_q;
    db_d = db_q;
    if (!enable) begin
      dr_d = R;
      dg_d = G;
      db_d = B;
    end else if (wrap) begin
`ifdef RGB_PWM_SOFT_FADE_EN
      dr_d = fade_step(dr_q, R);
      dg_d = fade_step(dg_q, G);
      db_d = fade_step(db_q, B);
`else
      dr_d = R;
      dg_d = G;
      db_d = B;
`endif
    end
  end

  // Output compare: cnt never exceeds 254, so duty 255 is always on and
  // duty 0 never on.
  always_comb begin
    led_r_d        = INACTIVE;
    led_g_d        = INACTIVE;
    led_b_d        = INACTIVE;
    period_start_d = 1'b0;
    if (enable) begin
      led_r_d        = (cnt_q < dr_q) ^ INACTIVE;
      led_g_d        = (cnt_q < dg_q) ^ INACTIVE;
      led_b_d        = (cnt_q < db_q) ^ INACTIVE;
      period_start_d = wrap;
    end
    settled_d = (dr_q == R) && (dg_q == G) && (db_q == B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q         <= 16'd0;
      cnt_q          <= 8'd0;
      dr_q           <= 8'd0;
      dg_q           <= 8'd0;
      db_q           <= 8'd0;
      led_r_q        <= INACTIVE;
      led_g_q        <= INACTIVE;
      led_b_q        <= INACTIVE;
      period_start_q <= 1'b0;
      settled_q      <= 1'b0;
    end else begin
      pcnt_q         <= pcnt_d;
      cnt_q          <= cnt_d;
      dr_q           <= dr_d;
      dg_q           <= dg_d;
      db_q           <= db_d;
      led_r_q        <= led_r_d;
      led_g_q        <= led_g_d;
      led_b_q        <= led_b_d;
      period_start_q <= period_start_d;
      settled_q      <= settled_d;
    end
  end

  assign led_r        = led_r_q;
  assign led_g        = led_g_q;
  assign led_b        = led_b_q;
  assign period_start = period_start_q;
  assign settled      = settled_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Testbench for rgb_pwm_driver: two instances (PRESC=2 active-high LED,
// PRESC=1 common-anode LED) share the same stimulus and are compared every
// cycle against a period/tick arithmetic model of the driver.

module tb_rgb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] r = 8'd0;
  logic [7:0] g = 8'd0;
  logic [7:0] b = 8'd0;

  logic led_r_a, led_g_a, led_b_a, ps_a, set_a;
  logic led_r_b, led_g_b, led_b_b, ps_b, set_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESC(2), .COMMON_ANODE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .R(r), .G(g), .B(b), .enable(enable),
    .led_r(led_r_a), .led_g(led_g_a), .led_b(led_b_a),
    .period_start(ps_a), .settled(set_a)
  );

  rgb_pwm_driver #(.PRESC(1), .COMMON_ANODE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .R(r), .G(g), .B(b), .enable(enable),
    .led_r(led_r_b), .led_g(led_g_b), .led_b(led_b_b),
    .period_start(ps_b), .settled(set_b)
  );

  // Reference model. mN is the number of enabled clocks since the current
  // period began; the counter value is derived from it arithmetically.
  int   mP [2] = '{2, 1};
  logic mCa [2] = '{1'b0, 1'b1};
  int   mN [2];
  int   mDuty [2][3];
  logic mLed [2][3];
  logic mPs [2];
  logic mSet [2];

  function automatic int fadeToward(input int cur, input int tgt);
    if (tgt > cur) return cur + 1;
    if (tgt < cur) return cur - 1;
    return cur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int tgt [3];
    int cntNow;
    bit allEq;
    tgt[0] = int'(r);
    tgt[1] = int'(g);
    tgt[2] = int'(b);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mN[i]   = 0;
        mPs[i]  = 1'b0;
        mSet[i] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          mDuty[i][c] = 0;
          mLed[i][c]  = mCa[i];
        end
      end else begin
        cntNow = (mN[i] / mP[i]) % 255;
        allEq  = 1'b1;
        for (int c = 0; c < 3; c++) begin
          mLed[i][c] = enable ? ((cntNow < mDuty[i][c]) ^ mCa[i]) : mCa[i];
          if (mDuty[i][c] != tgt[c]) allEq = 1'b0;
        end
        mSet[i] = allEq;
        if (!enable) begin
          mN[i]  = 0;
          mPs[i] = 1'b0;
          for (int c = 0; c < 3; c++) mDuty[i][c] = tgt[c];
        end else if (mN[i] + 1 == 255 * mP[i]) begin
          mN[i]  = 0;
          mPs[i] = 1'b1;
          for (int c = 0; c < 3; c++) begin
`ifdef RGB_PWM_SOFT_FADE_EN
            mDuty[i][c] = fadeToward(mDuty[i][c], tgt[c]);
`else
            mDuty[i][c] = tgt[c];
`endif
          end
        end else begin
          mN[i]  = mN[i] + 1;
          mPs[i] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input string step);
    checkOutput({step, " a.led_r"},        led_r_a, mLed[0][0]);
    checkOutput({step, " a.led_g"},        led_g_a, mLed[0][1]);
    checkOutput({step, " a.led_b"},        led_b_a, mLed[0][2]);
    checkOutput({step, " a.period_start"}, ps_a,    mPs[0]);
    checkOutput({step, " a.settled"},      set_a,   mSet[0]);
    checkOutput({step, " b.led_r"},        led_r_b, mLed[1][0]);
    checkOutput({step, " b.led_g"},        led_g_b, mLed[1][1]);
    checkOutput({step, " b.led_b"},        led_b_b, mLed[1][2]);
    checkOutput({step, " b.period_start"}, ps_b,    mPs[1]);
    checkOutput({step, " b.settled"},      set_b,   mSet[1]);
  endtask

  task automatic applyStimulus(input logic [7:0] nr, input logic [7:0] ng,
                               input logic [7:0] nb, input logic ne);
    r      = nr;
    g      = ng;
    b      = nb;
    enable = ne;
  endtask

  task automatic runCycles(input string step, input int n);
    repeat (n) begin
      @(negedge clk);
      checkAll(step);
    end
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic asyncReset(input string step);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkAll({step, " async"});
    checkOutput({step, " async a.led_r inactive"}, led_r_a, 1'b0);
    checkOutput({step, " async b.led_r inactive"}, led_r_b, 1'b1);
    @(negedge clk);
    checkAll({step, " held"});
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    $display("[TB] rgb_pwm_driver bench start");
    #1 rst_n = 1'b0;
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    checkAll("reset");
    checkOutput("reset a.settled", set_a, 1'b0);
    checkOutput("reset b.led_g", led_g_b, 1'b1);

    // Release with all duties zero
    rst_n = 1'b1;
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b1);
    runCycles("zero", 600);

    // Mid, zero and full duties
    applyStimulus(8'd128, 8'd0, 8'd255, 1'b1);
    runCycles("r128", 1100);

    // Mid-period change from 10 to 200 at cnt 50 on instance a
    applyStimulus(8'd10, 8'd0, 8'd255, 1'b1);
    runCycles("r10", 600);
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      checkAll("seek50");
      if ((mN[0] / mP[0]) % 255 == 50) found = 1'b1;
    end
    checkOutput("seek cnt50 within bound", found, 1'b1);
    applyStimulus(8'd200, 8'd0, 8'd255, 1'b1);
    runCycles("r200", 1100);

    // Enable falling in the wrap cycle of instance a
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      checkAll("seekwrap");
      if (mN[0] == 255 * mP[0] - 1) found = 1'b1;
    end
    checkOutput("seek wrap within bound", found, 1'b1);
    applyStimulus(8'd77, 8'd3, 8'd250, 1'b0);
    runCycles("disabled", 20);
    applyStimulus(8'd77, 8'd3, 8'd250, 1'b1);
    runCycles("reenable", 600);

    // Reset in the middle of a period, then reapply R=100
    applyStimulus(8'd100, 8'd40, 8'd1, 1'b1);
    runCycles("r100", 300);
    asyncReset("midreset");
    runCycles("after reset", 1200);

    // Randomised sequence of targets, enable drops and resets
    for (int it = 0; it < 10; it++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 4) != 0));
      runCycles("random", $urandom_range(50, 800));
      if ($urandom_range(0, 3) == 0) asyncReset("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
